lda_seq: RTL and testbench

- Time-multiplexed LDA classifier controller. One shared 8-bit multiply-accumulate unit computes the CLASSES discriminant inner products serially, one term per cycle.
- Afterwards, thresholds each discriminant, runs the fixed voting rule and emits a one-hot class.
- Holds the weight/threshold tables in local registers, loaded through a simple config port.
- Sits between the sensor-feature front end (valid/ready) and the downstream decision consumer (valid/ready).

---
 rtl/lda_pkg.sv | 24 ++
 rtl/lda_mac.sv | 19 +
 rtl/lda_seq.sv | 143 ++++++++++++++
 tb/tb_lda_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// lda_pkg : shared types and address map for the LDA classifier
// Rev 1.0
// ----------------------------------------------------------------
package lda_pkg;
  localparam int DIMS    = 6;
  localparam int CLASSES = 3;
  localparam int AW      = 5;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    VOTE = 2'd2,
    DONE = 2'd3
  } lda_state_e;

  // Weights w[i][j] live at W_BASE + i*CLASSES + j, thresholds follow.
  localparam int W_BASE = 0;
  localparam int C_BASE = DIMS * CLASSES;
endpackage
`default_nettype wire

// File: rtl/lda_mac.sv
`default_nettype none
// ----------------------------------------------------------------
// lda_mac : combinational 8-bit truncating multiply-add (acc + a*b)
// Rev 1.0
// ----------------------------------------------------------------
module lda_mac
  import lda_pkg::*;
(
  input  data_t i_acc,
  input  data_t i_a,
  input  data_t i_b,
  output data_t o_sum
);
  data_t w_prod;

  assign w_prod = i_a * i_b;
  assign o_sum  = i_acc + w_prod;
endmodule
`default_nettype wire

// File: rtl/lda_seq.sv
`default_nettype none
// ----------------------------------------------------------------
// lda_seq : time-multiplexed LDA classifier with fixed 3-class voting
// Rev 1.0
// ----------------------------------------------------------------
module lda_seq
  import lda_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  data_t [DIMS-1:0]   din_i,
  input  logic               cfg_we_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  data_t              cfg_data_i,
  output logic               cfg_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CLASSES-1:0] dout_o
);
  localparam int NW = DIMS * CLASSES;
  localparam int DW = $clog2(DIMS);
  localparam int CW = $clog2(CLASSES);
  localparam int IW = $clog2(NW);

  lda_state_e         r_state;
  data_t [DIMS-1:0]   r_din;
  data_t              r_w   [NW];
  data_t              r_c   [CLASSES];
  data_t              r_acc [CLASSES];
  logic [DW-1:0]      r_dim;
  logic [CW-1:0]      r_cls;
  logic               r_in_ready;
  logic               r_cfg_ready;
  logic               r_out_valid;
  logic [CLASSES-1:0] r_dout;

  logic [AW:0]        w_off_w;
  logic [AW:0]        w_off_c;
  logic               w_wr_w;
  logic               w_wr_c;
  logic [IW-1:0]      w_widx;
  data_t              w_sum;
  logic               w_gt0, w_gt1, w_gt2;
  logic [1:0]         w_v0, w_v1, w_v2;
  logic [CLASSES-1:0] w_dout;

  // Out-of-map addresses fall outside both windows and are silently dropped.
  assign w_off_w = {1'b0, cfg_addr_i} - (AW+1)'(W_BASE);
  assign w_off_c = {1'b0, cfg_addr_i} - (AW+1)'(C_BASE);
  assign w_wr_w  = cfg_we_i && r_cfg_ready && (w_off_w < (AW+1)'(NW));
  assign w_wr_c  = cfg_we_i && r_cfg_ready && (w_off_c < (AW+1)'(CLASSES));

  assign w_widx  = IW'(int'(r_dim) * CLASSES + int'(r_cls));

  lda_mac u_mac (
    .i_acc (r_acc[r_cls]),
    .i_a   (r_din[r_dim]),
    .i_b   (r_w[w_widx]),
    .o_sum (w_sum)
  );

  always_comb begin
    w_gt0 = r_acc[0] > r_c[0];
    w_gt1 = r_acc[1] > r_c[1];
    w_gt2 = r_acc[2] > r_c[2];
    w_v0  = 2'(!w_gt0) + 2'(!w_gt1) + 2'(!w_gt2);
    w_v1  = 2'(w_gt0);
    w_v2  = 2'(w_gt1) + 2'(w_gt2);
    if (w_v0 > w_v1 && w_v0 > w_v2)
      w_dout = CLASSES'(1);
    else if (w_v1 > w_v2)
      w_dout = CLASSES'(2);
    else
      w_dout = CLASSES'(4);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_din       <= '0;
      r_dim       <= '0;
      r_cls       <= '0;
      r_in_ready  <= 1'b1;
      r_cfg_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      for (int i = 0; i < NW; i++)      r_w[i]   <= '0;
      for (int i = 0; i < CLASSES; i++) r_c[i]   <= '0;
      for (int i = 0; i < CLASSES; i++) r_acc[i] <= '0;
    end else begin
      if (w_wr_w) r_w[w_off_w[IW-1:0]] <= cfg_data_i;
      if (w_wr_c) r_c[w_off_c[CW-1:0]] <= cfg_data_i;

      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_din      <= din_i;
            r_dim      <= '0;
            r_cls      <= '0;
            for (int i = 0; i < CLASSES; i++) r_acc[i] <= '0;
            r_in_ready  <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_state     <= MAC;
          end
        end
        MAC: begin
          r_acc[r_cls] <= w_sum;
          if (r_dim == DW'(DIMS - 1)) begin
            r_dim <= '0;
            if (r_cls == CW'(CLASSES - 1))
              r_state <= VOTE;
            else
              r_cls <= r_cls + CW'(1);
          end else begin
            r_dim <= r_dim + DW'(1);
          end
        end
        VOTE: begin
          r_dout      <= w_dout;
          r_out_valid <= 1'b1;
          r_cfg_ready <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign cfg_ready_o = r_cfg_ready;
  assign out_valid_o = r_out_valid;
  assign dout_o      = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_lda_seq.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_lda_seq : directed scoreboard bench for lda_seq
// Rev 1.0
// ----------------------------------------------------------------
`timescale 1ns/1ps
module tb_lda_seq;
  import lda_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               in_valid_i;
  logic               in_ready_o;
  data_t [DIMS-1:0]   din_i;
  logic               cfg_we_i;
  logic [AW-1:0]      cfg_addr_i;
  data_t              cfg_data_i;
  logic               cfg_ready_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [CLASSES-1:0] dout_o;

  int checks = 0;
  int errors = 0;
  logic [CLASSES-1:0] exp_q [$];

  lda_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .din_i       (din_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_ready_o (cfg_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .dout_o      (dout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is matched against the scoreboard head.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %b required no output", dout_o);
      end else begin
        chk("dout", 32'(dout_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we_i   = 1'b1;
    cfg_addr_i = AW'(addr);
    cfg_data_i = 8'(data);
    tick();
    cfg_we_i   = 1'b0;
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < DIMS * CLASSES; i++) cfg_write(i, v);
  endtask

  task automatic set_c(input int c0, input int c1, input int c2);
    cfg_write(C_BASE + 0, c0);
    cfg_write(C_BASE + 1, c1);
    cfg_write(C_BASE + 2, c2);
  endtask

  task automatic fill_din(input int v);
    for (int i = 0; i < DIMS; i++) din_i[i] = 8'(v);
  endtask

  task automatic accept(input logic [CLASSES-1:0] exp, input bit push);
    int n = 0;
    if (push) exp_q.push_back(exp);
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready_o=0 required 1");
    end
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid_o && edges < 60) begin tick(); edges++; end
    if (!out_valid_o) begin
      checks++; errors++;
      $display("FAIL out_timeout: got out_valid_o=0 required 1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready_o && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got in_ready_o=0 required 1");
    end
  endtask

  task automatic run(input logic [CLASSES-1:0] exp);
    int e;
    accept(exp, 1'b1);
    wait_out(e);
    wait_idle();
  endtask

  initial begin
    int e;
    logic [CLASSES-1:0] d0;
    rst_i = 1'b1; in_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
    cfg_data_i = '0; out_ready_i = 1'b1; din_i = '0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_dout", 32'(dout_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // acc = 12 in every class
    set_w(1); set_c(10, 10, 10); fill_din(2);
    accept(3'b100, 1'b1);
    wait_out(e);
    chk("latency", 32'(e), 32'd19);
    wait_idle();
    set_c(20, 20, 20); run(3'b001);
    set_c(10, 10, 20); run(3'b100);

    // Modulo-256 accumulation: 6*100 -> 88
    set_w(100); fill_din(1);
    set_c(87, 87, 87); run(3'b100);
    set_c(88, 88, 88); run(3'b001);

    // Truncated product: 200*2 -> 144
    set_w(0); cfg_write(0, 200); cfg_write(1, 200); cfg_write(2, 200);
    fill_din(2);
    set_c(143, 143, 143); run(3'b100);
    set_c(144, 144, 144); run(3'b001);

    // Backpressure in DONE
    set_w(1); set_c(10, 10, 10); fill_din(2);
    out_ready_i = 1'b0;
    accept(3'b100, 1'b1);
    wait_out(e);
    d0 = dout_o;
    chk("bp_dout_value", 32'(d0), 32'(3'b100));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_dout_stable", 32'(dout_o), 32'(d0));
      chk("bp_out_valid", 32'(out_valid_o), 32'd1);
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
      chk("bp_cfg_ready", 32'(cfg_ready_o), 32'd1);
    end
    out_ready_i = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid_o), 32'd0);
    chk("bp_release_idle", 32'(in_ready_o), 32'd1);

    // Config write during MAC is dropped
    set_c(20, 20, 10);
    accept(3'b001, 1'b1);
    repeat (4) tick();
    cfg_we_i = 1'b1; cfg_addr_i = AW'(C_BASE); cfg_data_i = 8'd0;
    chk("mac_cfg_ready", 32'(cfg_ready_o), 32'd0);
    tick();
    cfg_we_i = 1'b0;
    wait_out(e);
    wait_idle();
    cfg_write(C_BASE, 0);
    run(3'b100);

    // Reset in the middle of MAC
    accept(3'b000, 1'b0);
    repeat (6) tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_cfg_ready", 32'(cfg_ready_o), 32'd1);
    tick(); tick();
    rst_i = 1'b0;
    repeat (25) tick();
    chk("midrst_no_output", 32'(out_valid_o), 32'd0);
    fill_din(2);
    run(3'b001);

    // Back-to-back with in_valid_i held high
    set_w(1); set_c(15, 15, 15); fill_din(2);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    in_valid_i = 1'b1;
    tick();
    fill_din(3);
    wait_out(e);
    chk("b2b_latency1", 32'(e), 32'd19);
    tick();
    chk("b2b_hs_valid", 32'(out_valid_o), 32'd0);
    chk("b2b_hs_idle", 32'(in_ready_o), 32'd1);
    tick();
    chk("b2b_accept", 32'(in_ready_o), 32'd0);
    in_valid_i = 1'b0;
    wait_out(e);
    chk("b2b_latency2", 32'(e), 32'd19);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
